// File: rtl/preamble_insert.sv
// rtl/preamble_insert.sv - TX framer: LFSR sign-pattern preamble, then frame IQ pass-through
// Define PRE_GUARD_EN to insert GUARD_LEN zero samples between preamble and data.
module preamble_insert #(
  parameter int unsigned PRE_LEN   = 1024,
  parameter int unsigned PRE_REPS  = 2,
  parameter logic [15:0] AMP       = 16'h2000,
  parameter logic [9:0]  LFSR_SEED = 10'h3FF,
  parameter int unsigned GUARD_LEN = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cyc_i,
  input  logic        stb_i,
  output logic        ack_o,
  input  logic [31:0] dat_in,
  output logic        cyc_o,
  output logic        stb_o,
  output logic        we_o,
  input  logic        ack_i,
  output logic [31:0] dat_out,
  output logic        busy
);

  // One sample counter serves both the preamble repetition and the guard interval
  localparam int unsigned CNT_MAX = (PRE_LEN > GUARD_LEN) ? PRE_LEN : GUARD_LEN;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned RW      = $clog2(PRE_REPS + 1);
  localparam logic [15:0] NEG_AMP = ~AMP + 16'd1;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_GUARD, S_DATA, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rep_q, rep_d;
  logic [9:0]    lfsr_q, lfsr_d;
  logic          cyc_o_q, cyc_o_d;
  logic          stb_o_q, stb_o_d;
  logic [31:0]   dat_q, dat_d;
  logic          cyc_dly_q, cyc_dly_d;
  logic          out_halt;
  logic          out_take;

  function automatic logic [31:0] pre_sample(input logic [9:0] l);
    return {(l[1] ? NEG_AMP : AMP), (l[0] ? NEG_AMP : AMP)};
  endfunction

  function automatic logic [9:0] lfsr_next(input logic [9:0] l);
    return {l[8:0], l[9] ^ l[6]};
  endfunction

  assign out_halt = stb_o_q & ~ack_i;
  assign out_take = stb_o_q & ack_i;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rep_d     = rep_q;
    lfsr_d    = lfsr_q;
    cyc_o_d   = cyc_o_q;
    stb_o_d   = stb_o_q;
    dat_d     = dat_q;
    cyc_dly_d = cyc_i;
    ack_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cyc_i & ~cyc_dly_q) begin
          state_d = S_PRE;
          cyc_o_d = 1'b1;
          stb_o_d = 1'b1;
          lfsr_d  = LFSR_SEED;
          dat_d   = pre_sample(LFSR_SEED);
          cnt_d   = '0;
          rep_d   = '0;
        end
      end
      S_PRE: begin
        if (out_take) begin
          if (cnt_q == CW'(PRE_LEN - 1)) begin
            cnt_d  = '0;
            lfsr_d = LFSR_SEED;
            if (rep_q == RW'(PRE_REPS - 1)) begin
              rep_d = '0;
`ifdef PRE_GUARD_EN
              state_d = S_GUARD;
              dat_d   = '0;
`else
              state_d = S_DATA;
              stb_o_d = 1'b0;
`endif
            end else begin
              rep_d = rep_q + 1'b1;
              dat_d = pre_sample(LFSR_SEED);
            end
          end else begin
            cnt_d  = cnt_q + 1'b1;
            lfsr_d = lfsr_next(lfsr_q);
            dat_d  = pre_sample(lfsr_d);
          end
        end
      end
`ifdef PRE_GUARD_EN
      S_GUARD: begin
        if (out_take) begin
          if (cnt_q == CW'(GUARD_LEN - 1)) begin
            cnt_d   = '0;
            state_d = S_DATA;
            stb_o_d = 1'b0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
`endif
      S_DATA: begin
        ack_o = cyc_i & stb_i & ~out_halt;
        // Close only once any pending output word has been taken downstream
        if (~cyc_i & ~out_halt) begin
          state_d = S_DONE;
          cyc_o_d = 1'b0;
          stb_o_d = 1'b0;
        end else if (ack_o) begin
          dat_d   = dat_in;
          stb_o_d = 1'b1;
        end else if (~out_halt) begin
          stb_o_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cyc_o_d = 1'b0;
        stb_o_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rep_q     <= '0;
      lfsr_q    <= LFSR_SEED;
      cyc_o_q   <= 1'b0;
      stb_o_q   <= 1'b0;
      dat_q     <= '0;
      cyc_dly_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rep_q     <= rep_d;
      lfsr_q    <= lfsr_d;
      cyc_o_q   <= cyc_o_d;
      stb_o_q   <= stb_o_d;
      dat_q     <= dat_d;
      cyc_dly_q <= cyc_dly_d;
    end
  end

  assign cyc_o   = cyc_o_q;
  assign stb_o   = stb_o_q;
  assign we_o    = stb_o_q;
  assign dat_out = dat_q;
  assign busy    = (state_q != S_IDLE);

endmodule

// File: tb/tb_preamble_insert.sv
// tb/tb_preamble_insert.sv - directed self-checking bench for preamble_insert
module tb_preamble_insert;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc_i, stb_i, ack_i;
  logic        ack_o, cyc_o, stb_o, we_o, busy;
  logic [31:0] dat_in, dat_out;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  preamble_insert dut (
    .clk(clk), .rst(rst), .cyc_i(cyc_i), .stb_i(stb_i), .ack_o(ack_o),
    .dat_in(dat_in), .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o),
    .ack_i(ack_i), .dat_out(dat_out), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0; ack_i = 1'b1; dat_in = '0;
    repeat (3) step();
    total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL rst_cyc got=%b want=0", cyc_o); end
    total++; if (stb_o !== 1'b0 || we_o !== 1'b0) begin bad++; $display("FAIL rst_stb got=%b/%b want=0", stb_o, we_o); end
    total++; if (dat_out !== 32'h0) begin bad++; $display("FAIL rst_dat got=%h want=0", dat_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (ack_o !== 1'b0) begin bad++; $display("FAIL rst_ack got=%b want=0", ack_o); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_start();
    cyc_i = 1'b1; stb_i = 1'b1; dat_in = 32'h00010002; ack_i = 1'b1;
    #1;
    total++; if (ack_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL start_idle ack=%b busy=%b want 0/0", ack_o, busy); end
    step();
    total++; if (cyc_o !== 1'b1 || stb_o !== 1'b1 || we_o !== 1'b1) begin bad++; $display("FAIL start_stb cyc=%b stb=%b we=%b want 1/1/1", cyc_o, stb_o, we_o); end
    total++; if (dat_out !== 32'hE000E000) begin bad++; $display("FAIL start_dat got=%h want=E000E000", dat_out); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%b want=1", busy); end
  endtask

  task automatic test_preamble(input int halt_at, input bit keep_cyc);
    logic [9:0]  lf;
    logic [31:0] exp_s, s0, s1, s1024;
    int i, cyc_n, errs, ack_errs, g;
    lf = 10'h3FF; i = 0; cyc_n = 0; errs = 0; ack_errs = 0;
    s0 = '0; s1 = '0; s1024 = '1;
    cyc_i = keep_cyc; stb_i = keep_cyc; dat_in = 32'h00010002;
    while (i < 2048 && cyc_n < 3000) begin
      ack_i = !(halt_at >= 0 && cyc_n >= halt_at && cyc_n < halt_at + 5);
      #1;
      exp_s = {(lf[1] ? 16'hE000 : 16'h2000), (lf[0] ? 16'hE000 : 16'h2000)};
      if (stb_o !== 1'b1 || cyc_o !== 1'b1 || dat_out !== exp_s) errs++;
      if (ack_o !== 1'b0) ack_errs++;
      if (i == 0) s0 = dat_out;
      if (i == 1) s1 = dat_out;
      if (i == 1024) s1024 = dat_out;
      if (ack_i) begin
        i++;
        lf = (i % 1024 == 0) ? 10'h3FF : {lf[8:0], lf[9] ^ lf[6]};
      end
      step();
      cyc_n++;
    end
    total++; if (i !== 2048) begin bad++; $display("FAIL pre_timeout accepted=%0d want=2048", i); end
    total++; if (errs !== 0) begin bad++; $display("FAIL pre_seq errors=%0d want=0", errs); end
    total++; if (ack_errs !== 0) begin bad++; $display("FAIL pre_ack_o high_cycles=%0d want=0", ack_errs); end
    total++; if (s1 !== 32'hE0002000) begin bad++; $display("FAIL pre_sample1 got=%h want=E0002000", s1); end
    total++; if (s1024 !== s0) begin bad++; $display("FAIL pre_reload got=%h want=%h", s1024, s0); end
    ack_i = 1'b1;
    #1;
`ifdef PRE_GUARD_EN
    g = 0;
    while (stb_o === 1'b1 && dat_out === 32'h0 && g < 200) begin
      g++;
      step();
    end
    total++; if (g !== 64) begin bad++; $display("FAIL guard_len got=%0d want=64", g); end
`else
    g = 0;
`endif
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL pre_count extra strobe stb=%b want=0 (g=%0d)", stb_o, g); end
    total++; if (ack_o !== keep_cyc) begin bad++; $display("FAIL data_start ack=%b want=%b", ack_o, keep_cyc); end
  endtask

  task automatic test_data(input int halt_at);
    logic [31:0] prev_out;
    int up, dn, cyc_n, errs, hold_errs;
    bit halt, prev_halt;
    up = 0; dn = 0; cyc_n = 0; errs = 0; hold_errs = 0; prev_halt = 0; prev_out = '0;
    while (dn < 100 && cyc_n < 400) begin
      ack_i = !(halt_at >= 0 && cyc_n >= halt_at && cyc_n < halt_at + 5);
      if (up < 100) begin
        cyc_i = 1'b1; stb_i = 1'b1; dat_in = 32'h00010002 + up;
      end else begin
        cyc_i = 1'b0; stb_i = 1'b0; dat_in = '0;
      end
      #1;
      halt = (stb_o === 1'b1) && !ack_i;
      if (halt && ack_o !== 1'b0) hold_errs++;
      if (halt && prev_halt && dat_out !== prev_out) hold_errs++;
      if (stb_o === 1'b1 && ack_i) begin
        if (dat_out !== 32'h00010002 + dn) errs++;
        dn++;
      end
      prev_out = dat_out;
      prev_halt = halt;
      if (ack_o === 1'b1) up++;
      step();
      cyc_n++;
    end
    total++; if (dn !== 100 || up !== 100) begin bad++; $display("FAIL data_count out=%0d in=%0d want=100/100", dn, up); end
    total++; if (errs !== 0) begin bad++; $display("FAIL data_order errors=%0d want=0", errs); end
    total++; if (hold_errs !== 0) begin bad++; $display("FAIL data_hold errors=%0d want=0", hold_errs); end
    total++; if (cyc_o !== 1'b0 || stb_o !== 1'b0) begin bad++; $display("FAIL close_cyc cyc=%b stb=%b want 0/0", cyc_o, stb_o); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL close_busy_done got=%b want=1", busy); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL close_busy_idle got=%b want=0", busy); end
  endtask

  task automatic test_empty_close();
    total++; if (cyc_o !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL empty_data cyc=%b busy=%b want 1/1", cyc_o, busy); end
    step();
    total++; if (cyc_o !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL empty_done cyc=%b busy=%b want 0/1", cyc_o, busy); end
    step();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL empty_idle busy=%b want=0", busy); end
  endtask

  task automatic test_reset_mid();
    int n, cyc_n;
    test_start();
    n = 0; cyc_n = 0;
    while (n < 300 && cyc_n < 1000) begin
      if (stb_o === 1'b1) n++;
      step();
      cyc_n++;
    end
    rst = 1'b0; cyc_i = 1'b0; stb_i = 1'b0;
    step();
    total++; if (cyc_o !== 1'b0 || stb_o !== 1'b0 || we_o !== 1'b0) begin bad++; $display("FAIL midrst_ctl cyc=%b stb=%b we=%b want 0", cyc_o, stb_o, we_o); end
    total++; if (dat_out !== 32'h0 || busy !== 1'b0 || ack_o !== 1'b0) begin bad++; $display("FAIL midrst_dat dat=%h busy=%b ack=%b want 0", dat_out, busy, ack_o); end
    rst = 1'b1;
    step();
    cyc_i = 1'b1;
    step();
    total++; if (stb_o !== 1'b1 || cyc_o !== 1'b1 || dat_out !== 32'hE000E000) begin bad++; $display("FAIL midrst_restart stb=%b cyc=%b dat=%h want 1/1/E000E000", stb_o, cyc_o, dat_out); end
    rst = 1'b0; cyc_i = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_start();
    test_preamble(-1, 1'b1);
    test_data(-1);
    test_start();
    test_preamble(500, 1'b1);
    test_data(40);
    test_start();
    test_preamble(-1, 1'b0);
    test_empty_close();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
